// File: rtl/uart_pkg.sv
// Shared UART definitions: the receiver/transmitter state enum and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_START   = 3'd1,
    s_DATA    = 3'd2,
    s_STOP    = 3'd3,
    s_CLEANUP = 3'd4
  } uart_state_e;

  // 125 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 1085;
  localparam int CNT_W                = 11;

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between the serial pin, the receiver and the byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  // o_Rx_DV is a valid-only pulse with no ready: the consumer must accept o_Rx_Byte
  // in the DV cycle (the byte is also held until the next good frame).
  logic        i_Rx_Serial;
  logic        o_Rx_DV;
  logic [7:0]  o_Rx_Byte;
  logic        o_Rx_Frame_Err;
  logic        o_Rx_Active;
  uart_state_e o_State;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active, o_State
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active, o_State
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous, idle-high input; both flops reset to 1.
module sync_2ff (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_Async;
      r_sync <= r_meta;
    end
  end

  assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling and stop-bit framing check.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.master bus
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CENTRE = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic w_rx_s;
  logic w_sample;

  uart_state_e      r_state,  w_state;
  logic [CNT_W-1:0] r_count,  w_count;
  logic [2:0]       r_index,  w_index;
  logic [7:0]       r_shift,  w_shift;
  logic [7:0]       r_byte,   w_byte;
  logic             r_dv,     w_dv;
  logic             r_err,    w_err;
  logic             r_active, w_active;

  sync_2ff u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (bus.i_Rx_Serial),
    .o_Sync  (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [CNT_W-1:0] w_target;
  logic [1:0]       r_maj;

  // The two early votes are taken at the two counts preceding the decision count.
  assign w_target = (r_state == s_START) ? CENTRE : LAST;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_maj <= 2'b11;
    end else if (r_count == w_target - CNT_W'(2)) begin
      r_maj[0] <= w_rx_s;
    end else if (r_count == w_target - CNT_W'(1)) begin
      r_maj[1] <= w_rx_s;
    end
  end

  assign w_sample = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rx_s) | (r_maj[1] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state  <= s_IDLE;
      r_count  <= '0;
      r_index  <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_index  <= w_index;
      r_shift  <= w_shift;
      r_byte   <= w_byte;
      r_dv     <= w_dv;
      r_err    <= w_err;
      r_active <= w_active;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_count  = r_count + CNT_W'(1);
    w_index  = r_index;
    w_shift  = r_shift;
    w_byte   = r_byte;
    w_dv     = 1'b0;
    w_err    = 1'b0;
    w_active = r_active;
    case (r_state)
      s_IDLE: begin
        w_count = '0;
        w_index = '0;
        if (!w_rx_s) w_state = s_START;
      end
      s_START: begin
        if (r_count == CENTRE) begin
          w_count = '0;
          if (!w_sample) begin
            w_active = 1'b1;
            w_state  = s_DATA;
          end else begin
            w_state  = s_IDLE;
          end
        end
      end
      s_DATA: begin
        if (r_count == LAST) begin
          w_count          = '0;
          w_shift[r_index] = w_sample;
          if (r_index == 3'd7) w_state = s_STOP;
          else                 w_index = r_index + 3'd1;
        end
      end
      s_STOP: begin
        if (r_count == LAST) begin
          w_count  = '0;
          w_active = 1'b0;
          w_state  = s_CLEANUP;
          if (w_sample) begin
            w_byte = r_shift;
            w_dv   = 1'b1;
          end else begin
            w_err  = 1'b1;
          end
        end
      end
      s_CLEANUP: begin
        // A held-low line (break) parks here rather than re-triggering a frame.
        w_count = '0;
        if (w_rx_s) w_state = s_IDLE;
      end
      default: begin
        w_count = '0;
        w_state = s_IDLE;
      end
    endcase
  end

  assign bus.o_Rx_DV        = r_dv;
  assign bus.o_Rx_Byte      = r_byte;
  assign bus.o_Rx_Frame_Err = r_err;
  assign bus.o_Rx_Active    = r_active;
  assign bus.o_State        = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one full-rate instance for the 1085-cycle timing check and a
// shorter-period instance for the remaining scenarios. Honours UART_RX_MAJORITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB      = 200;
  localparam int CPB_FULL = CLKS_PER_BIT_DEFAULT;
  localparam int CPB_LONG = CPB * 103 / 100;
  localparam int CPB_SHRT = CPB * 97 / 100;

  logic clk;
  logic rst;
  int   cyc;
  int   t0;

  uart_rx_if bus_s ();
  uart_rx_if bus_f ();

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus_s)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_FULL)) u_dut_full (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus_f)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  initial begin
    cyc = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got_f_q[$];
  int         err_cnt, both_cnt, err_f_cnt, dv_f_cyc;
  bit         act_seen, act_f_seen;
  logic [7:0] last_good;
  int         n_checks, n_pass;

  always @(negedge clk) begin
    if (bus_s.o_Rx_DV) got_q.push_back(bus_s.o_Rx_Byte);
    if (bus_s.o_Rx_Frame_Err) err_cnt++;
    if (bus_s.o_Rx_DV && bus_s.o_Rx_Frame_Err) both_cnt++;
    if (bus_s.o_Rx_Active) act_seen = 1'b1;
    if (bus_f.o_Rx_DV) begin
      got_f_q.push_back(bus_f.o_Rx_Byte);
      dv_f_cyc = cyc + 1 - t0;
    end
    if (bus_f.o_Rx_Frame_Err) err_f_cnt++;
    if (bus_f.o_Rx_Active) act_f_seen = 1'b1;
  end

  // ---------------- drivers ----------------
  task automatic clear_mon();
    got_q.delete();
    got_f_q.delete();
    exp_q.delete();
    err_cnt    = 0;
    both_cnt   = 0;
    err_f_cnt  = 0;
    dv_f_cyc   = -1;
    act_seen   = 1'b0;
    act_f_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pin value for cycle n is applied at the negedge before posedge n; posedge 0 is
  // the first edge that registers the start bit. The line is left at the stop value.
  task automatic send_frame(input bit full, input logic [7:0] data, input int cpb,
                            input logic stop_bit, input int glitch_at);
    logic [9:0] bits;
    logic       v;
    bits = {stop_bit, data, 1'b0};
    for (int n = 0; n < 10 * cpb; n++) begin
      @(negedge clk);
      if (n == 0) t0 = cyc + 1;
      v = bits[n / cpb] ^ (n == glitch_at);
      if (full) bus_f.i_Rx_Serial = v;
      else      bus_s.i_Rx_Serial = v;
    end
  endtask

  task automatic check_queue(input string name);
    logic [7:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        $display("FAIL %s: byte missing, expected %02h", name, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) $display("FAIL %s: byte got %02h expected %02h", name, g, e);
        else n_pass++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_s.i_Rx_Serial = 1'b1;
    bus_f.i_Rx_Serial = 1'b1;
    idle(3);
    n_checks++; if (bus_s.o_Rx_DV !== 1'b0) $display("FAIL reset_dv: got %b expected 0", bus_s.o_Rx_DV); else n_pass++;
    n_checks++; if (bus_s.o_Rx_Byte !== 8'h00) $display("FAIL reset_byte: got %02h expected 00", bus_s.o_Rx_Byte); else n_pass++;
    n_checks++; if (bus_s.o_Rx_Frame_Err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus_s.o_Rx_Frame_Err); else n_pass++;
    n_checks++; if (bus_s.o_Rx_Active !== 1'b0) $display("FAIL reset_active: got %b expected 0", bus_s.o_Rx_Active); else n_pass++;
    n_checks++; if (bus_s.o_State !== s_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus_s.o_State, s_IDLE); else n_pass++;
    rst = 1'b0;
    idle(5);
    n_checks++; if (bus_f.o_State !== s_IDLE || bus_f.o_Rx_Byte !== 8'h00) $display("FAIL post_reset_full: state %0d byte %02h expected 0/00", bus_f.o_State, bus_f.o_Rx_Byte); else n_pass++;
  endtask

  task automatic test_full_rate();
    int exp_cyc;
    clear_mon();
    exp_cyc = 2 + ((CPB_FULL - 1) / 2 + 1) + 9 * CPB_FULL + 1;
    send_frame(1'b1, 8'hA5, CPB_FULL, 1'b1, -1);
    idle(20);
    n_checks++; if (got_f_q.size() !== 1) $display("FAIL full_dv_count: got %0d expected 1", got_f_q.size()); else n_pass++;
    n_checks++; if (got_f_q.size() == 0 || got_f_q[0] !== 8'hA5) $display("FAIL full_byte: got %02h expected a5", bus_f.o_Rx_Byte); else n_pass++;
    n_checks++; if (err_f_cnt !== 0) $display("FAIL full_err: got %0d expected 0", err_f_cnt); else n_pass++;
    n_checks++; if (dv_f_cyc < exp_cyc - 1 || dv_f_cyc > exp_cyc + 1) $display("FAIL full_dv_cycle: got %0d expected %0d", dv_f_cyc, exp_cyc); else n_pass++;
    n_checks++; if (act_f_seen !== 1'b1) $display("FAIL full_active: got %b expected 1", act_f_seen); else n_pass++;
  endtask

  task automatic test_idle_glitch();
    clear_mon();
    bus_s.i_Rx_Serial = 1'b0;
    idle(300 * CPB / CPB_FULL);
    bus_s.i_Rx_Serial = 1'b1;
    idle(2 * CPB);
    n_checks++; if (got_q.size() !== 0) $display("FAIL glitch_dv: got %0d expected 0", got_q.size()); else n_pass++;
    n_checks++; if (err_cnt !== 0) $display("FAIL glitch_err: got %0d expected 0", err_cnt); else n_pass++;
    n_checks++; if (act_seen !== 1'b0) $display("FAIL glitch_active: got %b expected 0", act_seen); else n_pass++;
    n_checks++; if (bus_s.o_State !== s_IDLE) $display("FAIL glitch_state: got %0d expected %0d", bus_s.o_State, s_IDLE); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rates[2];
    rates[0] = CPB_SHRT;
    rates[1] = CPB_LONG;
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h81);
      for (int i = 0; i < 3; i++) send_frame(1'b0, exp_q[i], rates[r], 1'b1, -1);
      idle(2 * CPB);
      n_checks++; if (got_q.size() !== 3) $display("FAIL b2b_count rate %0d: got %0d expected 3", rates[r], got_q.size()); else n_pass++;
      check_queue("b2b");
    end
    last_good = 8'h81;
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(1'b0, 8'h3C, CPB, 1'b0, -1);
    idle(3 * CPB);
    n_checks++; if (err_cnt !== 1) $display("FAIL ferr_count: got %0d expected 1", err_cnt); else n_pass++;
    n_checks++; if (got_q.size() !== 0) $display("FAIL ferr_dv: got %0d expected 0", got_q.size()); else n_pass++;
    n_checks++; if (bus_s.o_Rx_Byte !== last_good) $display("FAIL ferr_byte_held: got %02h expected %02h", bus_s.o_Rx_Byte, last_good); else n_pass++;
    n_checks++; if (bus_s.o_State !== s_CLEANUP) $display("FAIL ferr_break_state: got %0d expected %0d", bus_s.o_State, s_CLEANUP); else n_pass++;
    bus_s.i_Rx_Serial = 1'b1;
    idle(CPB);
    exp_q.push_back(8'h5A);
    send_frame(1'b0, 8'h5A, CPB, 1'b1, -1);
    idle(CPB);
    check_queue("ferr_recover");
    last_good = 8'h5A;
    n_checks++; if (both_cnt !== 0) $display("FAIL dv_err_overlap: got %0d expected 0", both_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    clear_mon();
    for (int n = 0; n < 5 * CPB + CPB / 2; n++) begin
      @(negedge clk);
      bus_s.i_Rx_Serial = bits[n / CPB];
    end
    rst = 1'b1;
    bus_s.i_Rx_Serial = 1'b1;
    idle(2);
    n_checks++; if ({bus_s.o_Rx_DV, bus_s.o_Rx_Frame_Err, bus_s.o_Rx_Active} !== 3'b000) $display("FAIL rst_mid_flags: got %b expected 000", {bus_s.o_Rx_DV, bus_s.o_Rx_Frame_Err, bus_s.o_Rx_Active}); else n_pass++;
    n_checks++; if (bus_s.o_Rx_Byte !== 8'h00) $display("FAIL rst_mid_byte: got %02h expected 00", bus_s.o_Rx_Byte); else n_pass++;
    n_checks++; if (bus_s.o_State !== s_IDLE) $display("FAIL rst_mid_state: got %0d expected %0d", bus_s.o_State, s_IDLE); else n_pass++;
    rst = 1'b0;
    idle(2 * CPB);
    n_checks++; if (got_q.size() !== 0 || err_cnt !== 0) $display("FAIL rst_mid_partial: dv %0d err %0d expected 0/0", got_q.size(), err_cnt); else n_pass++;
    exp_q.push_back(8'h96);
    send_frame(1'b0, 8'h96, CPB, 1'b1, -1);
    idle(CPB);
    check_queue("rst_mid_next");
    last_good = 8'h96;
  endtask

  task automatic test_bit_glitch();
    int at;
    clear_mon();
    // pin cycle that the receiver sees at its bit-3 decision edge
    at = (CPB - 1) / 2 + 1 + 4 * CPB;
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'hF0);
`else
    exp_q.push_back(8'hF0 ^ 8'h08);
`endif
    send_frame(1'b0, 8'hF0, CPB, 1'b1, at);
    idle(CPB);
    n_checks++; if (got_q.size() !== 1) $display("FAIL bitglitch_count: got %0d expected 1", got_q.size()); else n_pass++;
    check_queue("bitglitch");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         rate;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      d    = 8'($urandom_range(0, 255));
      rate = $urandom_range(CPB_SHRT, CPB_LONG);
      exp_q.push_back(d);
      send_frame(1'b0, d, rate, 1'b1, -1);
      idle($urandom_range(0, CPB));
    end
    idle(2 * CPB);
    n_checks++; if (err_cnt !== 0) $display("FAIL rand_err: got %0d expected 0", err_cnt); else n_pass++;
    check_queue("rand");
    n_checks++; if (got_q.size() !== 0) $display("FAIL rand_extra: got %0d extra bytes expected 0", got_q.size()); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    t0        = 0;
    last_good = 8'h00;
    test_reset();
    test_full_rate();
    test_idle_glitch();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_frame();
    test_bit_glitch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
